// File: rtl/cv32e40x_xif_aes_sched_pkg.sv
// cv32e40x_xif_aes_sched_pkg: AES32 encodings and scheduler types
package cv32e40x_xif_aes_sched_pkg;
  localparam logic [6:0] AES32 = 7'b0101011;
  localparam logic [4:0] AES32ESI = 5'b10001;
  localparam logic [4:0] AES32ESMI = 5'b10011;
  localparam logic [4:0] AES32DSI = 5'b10101;
  localparam logic [4:0] AES32DSMI = 5'b10111;
  typedef enum logic [3:0] {
    AES_NONE  = 4'b0000,
    AES_ENCS  = 4'b0001,
    AES_ENCSM = 4'b0010,
    AES_DECS  = 4'b0100,
    AES_DECSM = 4'b1000
  } aes_op_e;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} aes_sched_state_e;
  function automatic aes_op_e aes_decode(input logic [4:0] f);
    return f == AES32ESI ? AES_ENCS : f == AES32ESMI ? AES_ENCSM :
           f == AES32DSI ? AES_DECS : f == AES32DSMI ? AES_DECSM : AES_NONE;
  endfunction
endpackage

// File: rtl/cv32e40x_xif_aes_sched_if.sv
// cv32e40x_xif_aes_sched_if: issue, commit, result and FU channels of the AES32 scheduler
interface cv32e40x_xif_aes_sched_if #(
  parameter int X_ID_WIDTH = 4,
  parameter int X_RFR_WIDTH = 32
);
  logic issue_valid_i, issue_ready_o, issue_accept_o;
  logic [31:0] issue_instr_i;
  logic [X_ID_WIDTH-1:0] issue_id_i;
  logic [1:0] issue_rs_valid_i;
  logic [X_RFR_WIDTH-1:0] issue_rs1_i, issue_rs2_i;
  logic commit_valid_i, commit_kill_i;
  logic [X_ID_WIDTH-1:0] commit_id_i;
  logic fu_valid_o, fu_ready_i;
  logic [X_RFR_WIDTH-1:0] fu_rs1_o, fu_rs2_o, fu_rd_i;
  logic [1:0] fu_bs_o;
  logic [3:0] fu_op_o;
  logic result_valid_o, result_ready_i, result_we_o;
  logic [X_ID_WIDTH-1:0] result_id_o;
  logic [X_RFR_WIDTH-1:0] result_data_o;
  logic [4:0] result_rd_o;
  modport master (
    output issue_valid_i, issue_instr_i, issue_id_i, issue_rs_valid_i, issue_rs1_i, issue_rs2_i,
    output commit_valid_i, commit_id_i, commit_kill_i, fu_rd_i, fu_ready_i, result_ready_i,
    input issue_ready_o, issue_accept_o, fu_valid_o, fu_rs1_o, fu_rs2_o, fu_bs_o, fu_op_o,
    input result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
  );
  modport slave (
    input issue_valid_i, issue_instr_i, issue_id_i, issue_rs_valid_i, issue_rs1_i, issue_rs2_i,
    input commit_valid_i, commit_id_i, commit_kill_i, fu_rd_i, fu_ready_i, result_ready_i,
    output issue_ready_o, issue_accept_o, fu_valid_o, fu_rs1_o, fu_rs2_o, fu_bs_o, fu_op_o,
    output result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o
  );
endinterface

// File: rtl/cv32e40x_xif_aes_sched.sv
// cv32e40x_xif_aes_sched: in-order, commit-gated AES32 issue queue feeding the saes32 FU
module cv32e40x_xif_aes_sched
  import cv32e40x_xif_aes_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int X_ID_WIDTH = 4,
  parameter int X_RFR_WIDTH = 32
) (
  input logic clk_i,
  input logic rst_n,
  cv32e40x_xif_aes_sched_if.slave xif
);
  localparam int PW = $clog2(DEPTH);
  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [X_RFR_WIDTH-1:0] rs1;
    logic [X_RFR_WIDTH-1:0] rs2;
    logic [1:0] bs;
    aes_op_e op;
    logic [4:0] rd;
    logic committed;
    logic killed;
  } entry_t;
  entry_t q [DEPTH];
  entry_t hd;
  logic [DEPTH-1:0] v_q;
  logic [PW-1:0] head_q, tail_q;
  logic [PW:0] cnt_q;
  aes_sched_state_e state_q;
  aes_op_e op_d;
  logic push, pop, hit, new_hit, head_c, head_k;
  assign op_d = aes_decode(xif.issue_instr_i[29:25]);
  assign hd = q[head_q];
  // Head status looks ahead at this cycle's commit so dispatch starts the cycle after it
  assign hit = xif.commit_valid_i && hd.id == xif.commit_id_i;
  assign head_c = v_q[head_q] && (hd.committed || (hit && !xif.commit_kill_i && !hd.killed));
  assign head_k = v_q[head_q] && (hd.killed || (hit && xif.commit_kill_i && !hd.committed));
  assign pop = state_q == IDLE ? head_k : state_q == EXEC && xif.fu_ready_i;
  assign xif.issue_ready_o = rst_n && (cnt_q != (PW+1)'(DEPTH) || pop);
  assign xif.issue_accept_o = xif.issue_valid_i && xif.issue_instr_i[6:0] == AES32 &&
                              op_d != AES_NONE && &xif.issue_rs_valid_i && xif.issue_ready_o;
  assign push = xif.issue_accept_o;
  assign new_hit = xif.commit_valid_i && xif.commit_id_i == xif.issue_id_i;
  assign xif.fu_rs1_o = xif.fu_valid_o ? hd.rs1 : '0;
  assign xif.fu_rs2_o = xif.fu_valid_o ? hd.rs2 : '0;
  assign xif.fu_bs_o = xif.fu_valid_o ? hd.bs : 2'b00;
  assign xif.fu_op_o = xif.fu_valid_o ? hd.op : AES_NONE;
  assign xif.result_we_o = xif.result_valid_o;
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++)
      if (v_q[i] && xif.commit_valid_i && q[i].id == xif.commit_id_i) begin
        q[i].committed <= q[i].committed || (!xif.commit_kill_i && !q[i].killed);
        q[i].killed <= q[i].killed || (xif.commit_kill_i && !q[i].committed);
      end
    if (push)
      q[tail_q] <= '{id: xif.issue_id_i, rs1: xif.issue_rs1_i, rs2: xif.issue_rs2_i,
                     bs: xif.issue_instr_i[31:30], op: op_d, rd: xif.issue_instr_i[11:7],
                     committed: new_hit && !xif.commit_kill_i, killed: new_hit && xif.commit_kill_i};
  end
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q <= '0;
      v_q <= '0;
    end else begin
      if (pop) begin
        head_q <= head_q + 1'b1;
        v_q[head_q] <= 1'b0;
      end
      if (push) begin
        tail_q <= tail_q + 1'b1;
        v_q[tail_q] <= 1'b1;
      end
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      xif.fu_valid_o <= 1'b0;
      xif.result_valid_o <= 1'b0;
      xif.result_id_o <= '0;
      xif.result_data_o <= '0;
      xif.result_rd_o <= '0;
    end else
      case (state_q)
        IDLE: if (head_c) begin
          state_q <= EXEC;
          xif.fu_valid_o <= 1'b1;
        end
        EXEC: if (xif.fu_ready_i) begin
          state_q <= RESP;
          xif.fu_valid_o <= 1'b0;
          xif.result_valid_o <= 1'b1;
          xif.result_id_o <= hd.id;
          xif.result_data_o <= xif.fu_rd_i;
          xif.result_rd_o <= hd.rd;
        end
        RESP: if (xif.result_ready_i) begin
          state_q <= head_c ? EXEC : IDLE;
          xif.fu_valid_o <= head_c;
          xif.result_valid_o <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
endmodule

// File: tb/tb_cv32e40x_xif_aes_sched.sv
// tb_cv32e40x_xif_aes_sched: random + directed check of the AES32 scheduler against a queue model
module tb_cv32e40x_xif_aes_sched;
  localparam int DEPTH = 4;
  localparam int IW = 4;
  localparam int RW = 32;
  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk_i = ~clk_i;
  cv32e40x_xif_aes_sched_if #(.X_ID_WIDTH(IW), .X_RFR_WIDTH(RW)) xif();
  cv32e40x_xif_aes_sched #(.DEPTH(DEPTH), .X_ID_WIDTH(IW), .X_RFR_WIDTH(RW)) dut (
    .clk_i(clk_i),
    .rst_n(rst_n),
    .xif(xif.slave)
  );
  function automatic logic [31:0] fu_fn(logic [31:0] a, logic [31:0] b, logic [1:0] bs, logic [3:0] op);
    return a ^ {b[23:0], b[31:24]} ^ {26'h0, bs, op};
  endfunction
  assign xif.fu_rd_i = fu_fn(xif.fu_rs1_o, xif.fu_rs2_o, xif.fu_bs_o, xif.fu_op_o);
  function automatic logic [3:0] op_of(logic [31:0] ins);
    if (ins[6:0] != 7'b0101011) return 4'b0000;
    case (ins[29:25])
      5'b10001: return 4'b0001;
      5'b10011: return 4'b0010;
      5'b10101: return 4'b0100;
      5'b10111: return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction
  function automatic logic [31:0] mk(logic [1:0] bs, logic [4:0] f, logic [4:0] rd);
    return {bs, f, 13'h0, rd, 7'b0101011};
  endfunction
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask
  typedef struct {
    logic [IW-1:0] id;
    logic [31:0] rs1, rs2;
    logic [1:0] bs;
    logic [3:0] op;
    logic [4:0] rd;
    bit c, k;
  } ent_t;
  ent_t mq[$];
  int ph = 0;
  logic rv = 0;
  logic [IW-1:0] rid = 0;
  logic [31:0] rdat = 0;
  logic [4:0] rrd = 0;
  bit e_ready, e_acc, e_pop;
  logic [IW-1:0] fu_ids[$];
  logic [IW-1:0] res_ids[$];
  function automatic void comb();
    bit hit, hk;
    hit = xif.commit_valid_i && mq.size() > 0 && mq[0].id == xif.commit_id_i;
    hk = mq.size() > 0 && (mq[0].k || (hit && xif.commit_kill_i && !mq[0].c));
    e_pop = (ph == 0 && hk) || (ph == 1 && xif.fu_ready_i);
    e_ready = rst_n && (mq.size() < DEPTH || e_pop);
    e_acc = xif.issue_valid_i && op_of(xif.issue_instr_i) != 0 && xif.issue_rs_valid_i == 2'b11 && e_ready;
  endfunction
  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      ph = 0;
      rv = 0;
      rid = 0;
      rdat = 0;
      rrd = 0;
    end else begin
      ent_t e;
      bit nh;
      comb();
      foreach (mq[i])
        if (xif.commit_valid_i && mq[i].id == xif.commit_id_i) begin
          if (xif.commit_kill_i) begin
            if (!mq[i].c) mq[i].k = 1;
          end else if (!mq[i].k) mq[i].c = 1;
        end
      case (ph)
        0: if (mq.size() > 0 && mq[0].k) void'(mq.pop_front());
           else if (mq.size() > 0 && mq[0].c) ph = 1;
        1: if (xif.fu_ready_i) begin
          rv = 1;
          rid = mq[0].id;
          rrd = mq[0].rd;
          rdat = fu_fn(mq[0].rs1, mq[0].rs2, mq[0].bs, mq[0].op);
          void'(mq.pop_front());
          ph = 2;
        end
        default: if (xif.result_ready_i) begin
          rv = 0;
          ph = (mq.size() > 0 && mq[0].c) ? 1 : 0;
        end
      endcase
      if (e_acc) begin
        nh = xif.commit_valid_i && xif.commit_id_i == xif.issue_id_i;
        e.id = xif.issue_id_i;
        e.rs1 = xif.issue_rs1_i;
        e.rs2 = xif.issue_rs2_i;
        e.bs = xif.issue_instr_i[31:30];
        e.op = op_of(xif.issue_instr_i);
        e.rd = xif.issue_instr_i[11:7];
        e.c = nh && !xif.commit_kill_i;
        e.k = nh && xif.commit_kill_i;
        mq.push_back(e);
      end
    end
  end
  always @(negedge clk_i) begin
    bit ex;
    comb();
    ex = rst_n && ph == 1;
    chk("issue_ready", xif.issue_ready_o, e_ready);
    chk("issue_accept", xif.issue_accept_o, e_acc);
    chk("fu_valid", xif.fu_valid_o, ex);
    chk("fu_rs1", xif.fu_rs1_o, ex ? mq[0].rs1 : 32'h0);
    chk("fu_rs2", xif.fu_rs2_o, ex ? mq[0].rs2 : 32'h0);
    chk("fu_bs", xif.fu_bs_o, ex ? mq[0].bs : 2'b00);
    chk("fu_op", xif.fu_op_o, ex ? mq[0].op : 4'b0000);
    chk("result_valid", xif.result_valid_o, rv);
    chk("result_we", xif.result_we_o, rv);
    chk("result_id", xif.result_id_o, rid);
    chk("result_data", xif.result_data_o, rdat);
    chk("result_rd", xif.result_rd_o, rrd);
    if (xif.fu_valid_o && xif.fu_ready_i && ph == 1) fu_ids.push_back(mq[0].id);
    if (xif.result_valid_o && xif.result_ready_i) res_ids.push_back(xif.result_id_o);
  end
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic iss(logic [31:0] ins, logic [3:0] id, logic [31:0] a, logic [31:0] b);
    xif.issue_valid_i = 1;
    xif.issue_instr_i = ins;
    xif.issue_id_i = id;
    xif.issue_rs_valid_i = 2'b11;
    xif.issue_rs1_i = a;
    xif.issue_rs2_i = b;
  endtask
  task automatic cmt(logic [3:0] id, bit k);
    xif.commit_valid_i = 1;
    xif.commit_id_i = id;
    xif.commit_kill_i = k;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    int nf, nr, n;
    logic [4:0] fl [4] = '{5'b10001, 5'b10011, 5'b10101, 5'b10111};
    xif.issue_valid_i = 0;
    xif.issue_instr_i = 0;
    xif.issue_id_i = 0;
    xif.issue_rs_valid_i = 0;
    xif.issue_rs1_i = 0;
    xif.issue_rs2_i = 0;
    xif.commit_valid_i = 0;
    xif.commit_id_i = 0;
    xif.commit_kill_i = 0;
    xif.fu_ready_i = 1;
    xif.result_ready_i = 1;
    @(negedge clk_i);
    chk("rst_ready", xif.issue_ready_o, 0);
    chk("rst_fu_valid", xif.fu_valid_o, 0);
    chk("rst_res_valid", xif.result_valid_o, 0);
    chk("rst_res_data", xif.result_data_o, 0);
    tick();
    tick();
    rst_n = 1;
    @(negedge clk_i);
    chk("post_rst_ready", xif.issue_ready_o, 1);
    tick();
    iss(mk(2'b01, 5'b10001, 5'd5), 4'd3, 32'h0, 32'h0);
    @(negedge clk_i);
    chk("single_accept", xif.issue_accept_o, 1);
    tick();
    xif.issue_valid_i = 0;
    cmt(4'd3, 0);
    @(negedge clk_i);
    chk("single_no_early_exec", xif.fu_valid_o, 0);
    tick();
    xif.commit_valid_i = 0;
    @(negedge clk_i);
    chk("single_exec", xif.fu_valid_o, 1);
    chk("single_op", xif.fu_op_o, 4'b0001);
    chk("single_bs", xif.fu_bs_o, 2'b01);
    tick();
    @(negedge clk_i);
    chk("single_res_valid", xif.result_valid_o, 1);
    chk("single_res_id", xif.result_id_o, 3);
    chk("single_res_rd", xif.result_rd_o, 5);
    chk("single_res_data", xif.result_data_o, 32'h00000011);
    tick();
    nf = fu_ids.size();
    nr = res_ids.size();
    iss(mk(2'b00, 5'b10011, 5'd6), 4'd1, $urandom, $urandom);
    tick();
    iss(mk(2'b11, 5'b10101, 5'd7), 4'd2, $urandom, $urandom);
    tick();
    xif.issue_valid_i = 0;
    cmt(4'd1, 1);
    tick();
    cmt(4'd2, 0);
    tick();
    xif.commit_valid_i = 0;
    repeat (6) tick();
    chk("kill_fu_count", fu_ids.size() - nf, 1);
    chk("kill_fu_id", fu_ids[nf], 2);
    chk("kill_res_count", res_ids.size() - nr, 1);
    chk("kill_res_id", res_ids[nr], 2);
    for (int i = 0; i < DEPTH; i++) begin
      iss(mk(2'(i), fl[i], 5'(i + 10)), 4'(4 + i), $urandom, $urandom);
      tick();
    end
    iss(mk(2'b00, 5'b10111, 5'd9), 4'd8, $urandom, $urandom);
    cmt(4'd4, 0);
    @(negedge clk_i);
    chk("full_ready", xif.issue_ready_o, 0);
    chk("full_accept", xif.issue_accept_o, 0);
    tick();
    xif.commit_valid_i = 0;
    @(negedge clk_i);
    chk("full_pop_ready", xif.issue_ready_o, 1);
    chk("full_pop_accept", xif.issue_accept_o, 1);
    tick();
    xif.issue_valid_i = 0;
    for (int i = 5; i <= 8; i++) begin
      cmt(4'(i), 0);
      tick();
    end
    xif.commit_valid_i = 0;
    repeat (12) tick();
    xif.result_ready_i = 0;
    iss(mk(2'b10, 5'b10001, 5'd1), 4'd9, 32'h01234567, 32'h89abcdef);
    tick();
    iss(mk(2'b00, 5'b10111, 5'd2), 4'd10, 32'h01234567, 32'h89abcdef);
    cmt(4'd9, 0);
    tick();
    xif.issue_valid_i = 0;
    cmt(4'd10, 0);
    tick();
    xif.commit_valid_i = 0;
    @(negedge clk_i);
    n = 0;
    while (!xif.result_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("bp_wait", xif.result_valid_o, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk_i);
      chk("bp_hold_valid", xif.result_valid_o, 1);
      chk("bp_hold_id", xif.result_id_o, 9);
      chk("bp_hold_data", xif.result_data_o, 32'haaeeaacf);
      chk("bp_no_exec", xif.fu_valid_o, 0);
    end
    tick();
    xif.result_ready_i = 1;
    @(negedge clk_i);
    chk("bp_release_valid", xif.result_valid_o, 1);
    tick();
    @(negedge clk_i);
    chk("bp_direct_exec", xif.fu_valid_o, 1);
    tick();
    @(negedge clk_i);
    chk("bp_second_valid", xif.result_valid_o, 1);
    chk("bp_second_id", xif.result_id_o, 10);
    chk("bp_second_data", xif.result_data_o, 32'haaeeaae6);
    tick();
    nf = fu_ids.size();
    iss({2'b00, 5'b10001, 18'h0, 7'b0110011}, 4'd12, $urandom, $urandom);
    @(negedge clk_i);
    chk("filter_opcode", xif.issue_accept_o, 0);
    tick();
    iss(mk(2'b00, 5'b00000, 5'd3), 4'd13, $urandom, $urandom);
    @(negedge clk_i);
    chk("filter_funct", xif.issue_accept_o, 0);
    tick();
    xif.issue_valid_i = 0;
    cmt(4'd12, 0);
    tick();
    cmt(4'd13, 0);
    tick();
    xif.commit_valid_i = 0;
    repeat (4) tick();
    chk("filter_queue_empty", fu_ids.size() - nf, 0);
    xif.fu_ready_i = 0;
    iss(mk(2'b01, 5'b10011, 5'd4), 4'd14, $urandom, $urandom);
    tick();
    xif.issue_valid_i = 0;
    cmt(4'd14, 0);
    tick();
    xif.commit_valid_i = 0;
    @(negedge clk_i);
    chk("rst_mid_exec_stall", xif.fu_valid_o, 1);
    #3;
    rst_n = 0;
    #1;
    chk("arst_fu_valid", xif.fu_valid_o, 0);
    chk("arst_fu_rs1", xif.fu_rs1_o, 0);
    chk("arst_fu_op", xif.fu_op_o, 0);
    chk("arst_res_valid", xif.result_valid_o, 0);
    chk("arst_ready", xif.issue_ready_o, 0);
    tick();
    rst_n = 1;
    xif.fu_ready_i = 1;
    for (int i = 0; i < DEPTH; i++) begin
      iss(mk(2'b00, 5'b10001, 5'd1), 4'(i), $urandom, $urandom);
      @(negedge clk_i);
      chk("arst_count_zero", xif.issue_accept_o, 1);
      tick();
    end
    xif.issue_valid_i = 0;
    @(negedge clk_i);
    chk("arst_fsm_idle", xif.fu_valid_o, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cmt(4'(i), 1);
      tick();
    end
    xif.commit_valid_i = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) < 6) begin
        if ($urandom_range(0, 9) < 8)
          iss({2'($urandom), fl[$urandom_range(0, 3)], 13'($urandom), 5'($urandom), 7'b0101011},
              4'($urandom_range(0, 7)), $urandom, $urandom);
        else iss($urandom, 4'($urandom_range(0, 7)), $urandom, $urandom);
        if ($urandom_range(0, 9) == 0) xif.issue_rs_valid_i = 2'($urandom);
      end else xif.issue_valid_i = 0;
      xif.commit_valid_i = $urandom_range(0, 9) < 4;
      xif.commit_id_i = 4'($urandom_range(0, 7));
      xif.commit_kill_i = $urandom_range(0, 3) == 0;
      xif.fu_ready_i = $urandom_range(0, 9) < 7;
      xif.result_ready_i = $urandom_range(0, 9) < 6;
      tick();
    end
    xif.issue_valid_i = 0;
    xif.commit_kill_i = 0;
    xif.fu_ready_i = 1;
    xif.result_ready_i = 1;
    for (int c = 0; c < 64; c++) begin
      cmt(4'(c % 8), 0);
      tick();
    end
    xif.commit_valid_i = 0;
    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
